// File: rtl/gain_scaler.sv
// gain_scaler: streams words from an input RAM, scales each by an
// unsigned gain with shift and optional saturation, writes an output RAM.
module gain_scaler #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 8,
  parameter int CNT_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                rst,
  output logic [31:0]         rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [31:0]         wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_en,
  input  logic [CNT_W-1:0]    num_of_inp,
  input  logic [GAIN_W-1:0]   gain,
  input  logic [5:0]          shift,
  input  logic                sat_en,
  input  logic                start,
  output logic                busy,
  output logic                done
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = DATA_W + GAIN_W;
  localparam logic [31:0] STRIDE = 32'(BE_W);
  localparam logic [6:0]  PW7    = 7'(PW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         rd_addr_q, rd_addr_d;
  logic                rd_vld_q, rd_vld_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0]   tag_q, tag_d;
  logic [CNT_W-1:0]    num_q, num_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic [5:0]          shift_q, shift_d;
  logic                sat_q, sat_d;
  logic [31:0]         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [PW-1:0]       prod;
  logic [PW-1:0]       shifted;
  logic [DATA_W-1:0]   res;

  assign rst     = ~rst_n;
  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = {BE_W{wr_en_q}};
  assign busy    = busy_q;
  assign done    = done_q;

  // Full-width product, shift, then saturate or truncate.
  always_comb begin
    prod = {{GAIN_W{1'b0}}, rd_data}
         * {{DATA_W{1'b0}}, gain_q};
    if ({1'b0, shift_q} >= PW7) begin
      shifted = '0;
    end else begin
      shifted = prod >> shift_q;
    end
    if (sat_q && (|shifted[PW-1:DATA_W])) begin
      res = '1;
    end else begin
      res = shifted[DATA_W-1:0];
    end
  end

  // Next-state: job control, read issue, tag pipe and write path.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_vld_d  = 1'b0;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    tag_d     = (tag_q << 1) | RD_LAT'(rd_vld_q);
    num_d     = num_q;
    gain_d    = gain_q;
    shift_d   = shift_q;
    sat_d     = sat_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_of_inp;
          gain_d  = gain;
          shift_d = shift;
          sat_d   = sat_en;
          done_d  = 1'b0;
          if (num_of_inp == '0) begin
            done_d = 1'b1;
          end else begin
            rd_addr_d = '0;
            rd_vld_d  = 1'b1;
            rd_cnt_d  = CNT_W'(1);
            wr_cnt_d  = '0;
            busy_d    = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (rd_cnt_q == num_q) begin
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + STRIDE;
          rd_cnt_d  = rd_cnt_q + 1'b1;
          rd_vld_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (wr_cnt_q == num_q) begin
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rd_addr_d = '0;
          wr_addr_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (tag_q[RD_LAT-1]) begin
      wr_data_d = res;
      wr_en_d   = 1'b1;
      wr_addr_d = 32'(wr_cnt_q) * STRIDE;
      wr_cnt_d  = wr_cnt_q + 1'b1;
    end
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      tag_q     <= '0;
      num_q     <= '0;
      gain_q    <= '0;
      shift_q   <= '0;
      sat_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_vld_q  <= rd_vld_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      tag_q     <= tag_d;
      num_q     <= num_d;
      gain_q    <= gain_d;
      shift_q   <= shift_d;
      sat_q     <= sat_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_gain_scaler.sv
// tb_gain_scaler: two DUTs (read latency 1 and 3) on shared controls,
// checked cycle by cycle against a timing and arithmetic model.
module tb_gain_scaler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  num_of_inp;
  logic [7:0]  gain;
  logic [5:0]  shift;
  logic        sat_en;
  logic        start;

  logic        rst_a     [2];
  logic [31:0] rd_addr_a [2];
  logic [31:0] rd_data_a [2];
  logic [31:0] wr_addr_a [2];
  logic [31:0] wr_data_a [2];
  logic [3:0]  wr_en_a   [2];
  logic        busy_a    [2];
  logic        done_a    [2];

  logic [31:0] mem   [0:63];
  logic [31:0] exp_q [0:63];
  logic [31:0] p1;
  logic [31:0] p3    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gain_scaler #(.RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .rst(rst_a[0]),
    .rd_addr(rd_addr_a[0]), .rd_data(rd_data_a[0]),
    .wr_addr(wr_addr_a[0]), .wr_data(wr_data_a[0]),
    .wr_en(wr_en_a[0]), .num_of_inp(num_of_inp),
    .gain(gain), .shift(shift), .sat_en(sat_en),
    .start(start), .busy(busy_a[0]), .done(done_a[0])
  );

  gain_scaler #(.RD_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .rst(rst_a[1]),
    .rd_addr(rd_addr_a[1]), .rd_data(rd_data_a[1]),
    .wr_addr(wr_addr_a[1]), .wr_data(wr_data_a[1]),
    .wr_en(wr_en_a[1]), .num_of_inp(num_of_inp),
    .gain(gain), .shift(shift), .sat_en(sat_en),
    .start(start), .busy(busy_a[1]), .done(done_a[1])
  );

  // RAM models: data appears RD_LAT cycles after the address.
  always @(posedge clk) begin
    p1    <= mem[rd_addr_a[0][7:2]];
    p3[0] <= mem[rd_addr_a[1][7:2]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign rd_data_a[0] = p1;
  assign rd_data_a[1] = p3[2];

  typedef struct {
    int          n;
    logic [7:0]  g;
    logic [5:0]  sh;
    logic        sat;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(
    input logic [31:0] d, input logic [7:0] g,
    input logic [5:0] sh, input logic s);
    logic [63:0] p;
    logic [63:0] q;
    p = {32'b0, d} * {56'b0, g};
    q = (sh >= 6'd40) ? 64'd0 : (p >> sh);
    if (s && q > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  // Starts a job in the current cycle (cycle 0) and checks
  // both DUTs every cycle until the slower one reports done.
  task automatic run_job(input int n, input logic [7:0] g,
                         input logic [5:0] sh, input logic s,
                         input bit perturb);
    int  last;
    int  lat;
    int  idx;
    bit  we;
    bit  bz;
    bit  dn;
    num_of_inp = 10'(n);
    gain       = g;
    shift      = sh;
    sat_en     = s;
    start      = 1'b1;
    last = (n == 0) ? 3 : n + 5;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        lat = (j == 0) ? 1 : 3;
        if (n == 0) begin
          we = 1'b0; bz = 1'b0; dn = 1'b1;
        end else begin
          we = (k >= lat + 2) && (k <= n + lat + 1);
          bz = (k <= n + lat + 1);
          dn = (k >= n + lat + 2);
        end
        chk($sformatf("wr_en L%0d n%0d c%0d", lat, n, k),
            64'(wr_en_a[j]), we ? 64'hF : 64'h0);
        chk($sformatf("busy L%0d n%0d c%0d", lat, n, k),
            64'(busy_a[j]), 64'(bz));
        chk($sformatf("done L%0d n%0d c%0d", lat, n, k),
            64'(done_a[j]), 64'(dn));
        if (we) begin
          idx = k - lat - 2;
          chk($sformatf("wr_addr L%0d i%0d", lat, idx),
              64'(wr_addr_a[j]), 64'(idx * 4));
          chk($sformatf("wr_data L%0d i%0d", lat, idx),
              64'(wr_data_a[j]), 64'(exp_q[idx]));
        end
        if (n > 0 && k <= n) begin
          chk($sformatf("rd_addr L%0d c%0d", lat, k),
              64'(rd_addr_a[j]), 64'((k - 1) * 4));
        end
      end
      if (k == 1) start = 1'b0;
      if (perturb && k == 2) begin
        start      = 1'b1;
        gain       = ~g;
        shift      = sh + 6'd1;
        num_of_inp = 10'(n + 3);
      end
      if (perturb && k == 3) start = 1'b0;
    end
  endtask

  task automatic fill_rand(input int n, input logic [7:0] g,
                           input logic [5:0] sh, input logic s);
    for (int i = 0; i < n; i++) begin
      mem[i]   = $urandom;
      exp_q[i] = model(mem[i], g, sh, s);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rg;
    logic [5:0]  rs;
    logic        rt;
    int          rn;

    tbl[0] = '{1, 8'd2,   6'd0,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[1] = '{1, 8'd2,   6'd0,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2] = '{1, 8'd2,   6'd1,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3] = '{2, 8'd5,   6'd2,  1'b0, 32'd100,       32'd125};
    tbl[4] = '{2, 8'd5,   6'd40, 1'b1, 32'd100,       32'd0};
    tbl[5] = '{3, 8'd255, 6'd8,  1'b0, 32'h1234,      32'h1221};
    tbl[6] = '{1, 8'd1,   6'd0,  1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_of_inp = '0;
    gain       = '0;
    shift      = '0;
    sat_en     = 1'b0;

    repeat (3) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk("reset rst", 64'(rst_a[j]), 64'd1);
      chk("reset rd_addr", 64'(rd_addr_a[j]), 64'd0);
      chk("reset wr_addr", 64'(wr_addr_a[j]), 64'd0);
      chk("reset wr_data", 64'(wr_data_a[j]), 64'd0);
      chk("reset wr_en", 64'(wr_en_a[j]), 64'd0);
      chk("reset busy", 64'(busy_a[j]), 64'd0);
      chk("reset done", 64'(done_a[j]), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mem[i]   = 32'(i + 1);
      exp_q[i] = 32'(3 * (i + 1));
    end
    run_job(4, 8'd3, 6'd0, 1'b0, 1'b0);

    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        mem[i]   = tbl[t].d;
        exp_q[i] = tbl[t].e;
      end
      run_job(tbl[t].n, tbl[t].g, tbl[t].sh, tbl[t].sat, 1'b0);
    end

    run_job(0, 8'd9, 6'd0, 1'b0, 1'b0);

    fill_rand(6, 8'd7, 6'd1, 1'b0);
    run_job(6, 8'd7, 6'd1, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      rn = (r == 0) ? 16 : int'($urandom_range(1, 20));
      rg = 8'($urandom_range(0, 255));
      rs = (r == 3) ? 6'd40 : 6'($urandom_range(0, 12));
      rt = 1'($urandom_range(0, 1));
      fill_rand(rn, rg, rs, rt);
      run_job(rn, rg, rs, rt, 1'b0);
    end

    fill_rand(8, 8'd4, 6'd0, 1'b1);
    num_of_inp = 10'd8;
    gain       = 8'd4;
    shift      = 6'd0;
    sat_en     = 1'b1;
    start      = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst out L1", 64'(rst_a[0]), 64'd1);
    chk("rst out L3", 64'(rst_a[1]), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 5; k <= 16; k++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("midrst wr_en c%0d", k),
            64'(wr_en_a[j]), 64'd0);
        chk($sformatf("midrst busy c%0d", k),
            64'(busy_a[j]), 64'd0);
        chk($sformatf("midrst done c%0d", k),
            64'(done_a[j]), 64'd0);
        if (k == 5) begin
          chk("midrst rd_addr", 64'(rd_addr_a[j]), 64'd0);
          chk("midrst wr_addr", 64'(wr_addr_a[j]), 64'd0);
          chk("midrst wr_data", 64'(wr_data_a[j]), 64'd0);
          chk("midrst rst", 64'(rst_a[j]), 64'd0);
        end
      end
    end

    fill_rand(5, 8'd200, 6'd3, 1'b1);
    run_job(5, 8'd200, 6'd3, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
